// File: rtl/scpu_trace_buf.sv
// Retirement trace buffer: circular capture of {pc, instr, wdata} around a PC trigger, then drained oldest-first.
// Optional macro TRACE_REGWRITE_FILTER_EN restricts capture to register-writing instructions.
module scpu_trace_buf #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned POST  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      commit,
  input  logic [31:0]               pc,
  input  logic [31:0]               instr,
  input  logic [DW-1:0]             wdata,
  input  logic                      regwrite,
  input  logic                      arm,
  input  logic [31:0]               trig_pc,
  input  logic                      rd_en,
  output logic [63+DW:0]            rd_data,
  output logic                      rd_valid,
  output logic [1:0]                state,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 64 + DW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } stateT;

  stateT          curState, nxtState;
  logic [AW-1:0]  wrPtr, nxtWrPtr;
  logic [AW-1:0]  rdPtr, nxtRdPtr;
  logic [CW-1:0]  nxtCount;
  logic [AW-1:0]  postCnt, nxtPostCnt;
  logic           nxtValid;
  logic [EW-1:0]  nxtData;
  logic           capture_c;
  logic           capEn_c;
  logic [EW-1:0]  mem [DEPTH];

  // Capture qualifier: commit while collecting, optionally only for register writers
`ifdef TRACE_REGWRITE_FILTER_EN
  assign capEn_c = commit && regwrite && (curState == ST_ARMED || curState == ST_POST);
`else
  logic unusedRegwrite;
  assign unusedRegwrite = regwrite;
  assign capEn_c = commit && (curState == ST_ARMED || curState == ST_POST);
`endif

  assign state = curState;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curState <= ST_IDLE;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      postCnt  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      curState <= nxtState;
      wrPtr    <= nxtWrPtr;
      rdPtr    <= nxtRdPtr;
      count    <= nxtCount;
      postCnt  <= nxtPostCnt;
      rd_valid <= nxtValid;
      rd_data  <= nxtData;
    end
  end

  // Trace storage; contents are don't-care until written after an arm
  always_ff @(posedge clk) begin
    if (capture_c) mem[wrPtr] <= {pc, instr, wdata};
  end

  always_comb begin
    nxtState   = curState;
    nxtWrPtr   = wrPtr;
    nxtRdPtr   = rdPtr;
    nxtCount   = count;
    nxtPostCnt = postCnt;
    nxtValid   = 1'b0;
    nxtData    = rd_data;
    capture_c  = 1'b0;

    if (arm) begin
      nxtState   = ST_ARMED;
      nxtWrPtr   = '0;
      nxtRdPtr   = '0;
      nxtCount   = '0;
      nxtPostCnt = '0;
    end else begin
      unique case (curState)
        ST_ARMED, ST_POST: begin
          if (capEn_c) begin
            capture_c = 1'b1;
            nxtWrPtr  = wrPtr + AW'(1);
            if (count != CW'(DEPTH)) nxtCount = count + CW'(1);
            if (curState == ST_ARMED) begin
              if (pc == trig_pc) begin
                if (POST == 1) begin
                  nxtState = ST_DONE;
                end else begin
                  nxtPostCnt = AW'(POST - 1);
                  nxtState   = ST_POST;
                end
              end
            end else if (postCnt <= AW'(1)) begin
              // Last post-trigger entry: counter reaches zero here
              nxtPostCnt = '0;
              nxtState   = ST_DONE;
            end else begin
              nxtPostCnt = postCnt - AW'(1);
            end
          end
        end
        ST_DONE: begin
          if (rd_en && count != '0) begin
            nxtValid = 1'b1;
            nxtData  = mem[rdPtr];
            nxtRdPtr = rdPtr + AW'(1);
            nxtCount = count - CW'(1);
            if (count == CW'(1)) nxtState = ST_IDLE;
          end
        end
        default: ;
      endcase
    end

    // On entry to DONE point the read pointer at the oldest stored entry
    if (nxtState == ST_DONE && curState != ST_DONE) nxtRdPtr = nxtWrPtr - AW'(nxtCount);
  end

endmodule

// File: tb/tb_scpu_trace_buf.sv
// Self-checking bench for scpu_trace_buf: directed scenarios plus random traffic against a queue-based model.
module tb_scpu_trace_buf;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned POST  = 8;
  localparam int unsigned EW    = 64 + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          commit;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic [DW-1:0] wdata;
  logic          regwrite;
  logic          arm;
  logic [31:0]   trig_pc;
  logic          rd_en;
  logic [EW-1:0] rd_data;
  logic          rd_valid;
  logic [1:0]    state;
  logic [4:0]    count;

  int errCnt = 0;
  int chkCnt = 0;

  // Reference model: queue of captured entries, phase 0..3, remaining post entries
  logic [EW-1:0] mq[$];
  int            mState;
  int            mRemain;
  logic          mValid;
  logic [EW-1:0] mData;

  always #5 clk = ~clk;

  scpu_trace_buf #(.DW(DW), .DEPTH(DEPTH), .POST(POST)) dut (
    .clk(clk), .rst(rst), .commit(commit), .pc(pc), .instr(instr), .wdata(wdata),
    .regwrite(regwrite), .arm(arm), .trig_pc(trig_pc), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .state(state), .count(count)
  );

  task automatic checkEq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    chkCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit captureOk(input logic rw);
`ifdef TRACE_REGWRITE_FILTER_EN
    return rw;
`else
    return 1'b1;
`endif
  endfunction

  task automatic modelEdge();
    mValid = 1'b0;
    if (arm) begin
      mq.delete();
      mState  = 1;
      mRemain = 0;
    end else if (mState == 1 || mState == 2) begin
      if (commit && captureOk(regwrite)) begin
        mq.push_back({pc, instr, wdata});
        if (mq.size() > DEPTH) void'(mq.pop_front());
        if (mState == 1 && pc == trig_pc) begin
          mRemain = POST - 1;
          mState  = (mRemain == 0) ? 3 : 2;
        end else if (mState == 2) begin
          mRemain--;
          if (mRemain == 0) mState = 3;
        end
      end
    end else if (mState == 3) begin
      if (rd_en && mq.size() > 0) begin
        mData  = mq.pop_front();
        mValid = 1'b1;
        if (mq.size() == 0) mState = 0;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkEq({tag, ".state"}, 128'(state), 128'(mState));
    checkEq({tag, ".count"}, 128'(count), 128'(mq.size()));
    checkEq({tag, ".rd_valid"}, 128'(rd_valid), 128'(mValid));
    checkEq({tag, ".rd_data"}, 128'(rd_data), 128'(mData));
  endtask

  task automatic step(input logic a, input logic c, input logic [31:0] p,
                      input logic rw, input logic re, input string tag);
    arm = a; commit = c; pc = p; regwrite = rw; rd_en = re;
    instr = $urandom; wdata = $urandom;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(tag);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    mq.delete(); mState = 0; mRemain = 0; mValid = 1'b0; mData = '0;
    checkAll(tag);
    #1 rst = 1'b1;
  endtask

  logic          rA, rC, rRw, rRe;
  logic [31:0]   rP;

  initial begin
    rst = 1'b1; arm = 0; commit = 0; pc = 0; instr = 0; wdata = 0; regwrite = 0;
    trig_pc = 0; rd_en = 0;
    mq.delete(); mState = 0; mRemain = 0; mValid = 1'b0; mData = '0;
    #1 rst = 1'b0;
    #1 checkAll("reset0");
    #2 rst = 1'b1;

    // Trigger at 0x40 with more than DEPTH commits before the end of capture
    trig_pc = 32'h40;
    step(1, 0, 0, 0, 0, "arm36");
    for (int i = 0; i < 24; i++) step(0, 1, 32'(i * 4), 1, 0, "cap36");
    checkEq("req36.done", 128'(state), 128'(3));
    checkEq("req36.count", 128'(count), 128'(16));
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 0, 1, "pop36");
      checkEq("req36.pc", 128'(rd_data[EW-1 -: 32]), 128'(32'h20 + 32'(4 * i)));
    end
    checkEq("req36.idle", 128'(state), 128'(0));
    step(0, 0, 0, 0, 1, "idlepop");

    // Trigger on the third commit
    trig_pc = 32'h1008;
    step(1, 0, 0, 0, 0, "arm37");
    for (int i = 0; i < 10; i++) step(0, 1, 32'h1000 + 32'(4 * i), 1, 0, "cap37");
    checkEq("req37.done", 128'(state), 128'(3));
    checkEq("req37.count", 128'(count), 128'(10));
    step(0, 0, 0, 0, 1, "pop37");
    checkEq("req37.first", 128'(rd_data[EW-1 -: 32]), 128'(32'h1000));

    // Arm with rd_en in DONE: no pop, buffer cleared
    step(1, 0, 0, 0, 1, "armpop");
    checkEq("req39.valid", 128'(rd_valid), 128'(0));
    checkEq("req39.state", 128'(state), 128'(1));
    checkEq("req39.count", 128'(count), 128'(0));

    // Reset in the middle of POST
    trig_pc = 32'h40;
    step(0, 1, 32'h40, 1, 0, "trig38");
    step(0, 1, 32'h44, 1, 0, "post38");
    checkEq("req38.post", 128'(state), 128'(2));
    doReset("req38.rst");
    step(0, 0, 0, 0, 1, "req38.pop");

    // Regwrite filter on the trigger commit
    trig_pc = 32'h80;
    step(1, 0, 0, 0, 0, "arm40");
    step(0, 1, 32'h80, 0, 0, "rw0");
`ifdef TRACE_REGWRITE_FILTER_EN
    checkEq("req40.first", 128'(state), 128'(1));
`else
    checkEq("req40.first", 128'(state), 128'(2));
`endif
    step(0, 1, 32'h80, 1, 0, "rw1");
    checkEq("req40.second", 128'(state), 128'(2));

    // Random traffic with occasional re-arm, retrigger attempts and resets
    trig_pc = 32'h100;
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) doReset("rand.rst");
      rA  = (mState == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      rC  = ($urandom_range(0, 3) != 0);
      rP  = ($urandom_range(0, 5) == 0) ? trig_pc : (32'($urandom_range(0, 63)) << 2);
      rRw = 1'($urandom_range(0, 1));
      rRe = 1'($urandom_range(0, 1));
      step(rA, rC, rP, rRw, rRe, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
